// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences one DSP48E1 slice as a signed multiply-accumulate
// engine. Terms arrive on a valid/ready stream, operands and opmode tags are fed to
// the slice, and each finished dot product is read back from P and offered on a
// valid/ready result port.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid & ready are both 1. A valid holder keeps its payload stable until that edge.
//
// Optional feature macro: DSPMAC_TERM_LIMIT_EN (closes a dot product after MAX_TERMS
// terms and flags it with m_trunc).
module dsp_mac_sequencer #(
    parameter int P_LAT     = 3,
    parameter int OPM_DLY   = 1,
    parameter int MAX_TERMS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [24:0] s_a,
    input  logic [17:0] s_b,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic [15:0] m_count,
    output logic        m_trunc,
    output logic [29:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [6:0]  dsp_opmode,
    output logic [3:0]  dsp_alumode,
    output logic [4:0]  dsp_inmode,
    output logic [2:0]  dsp_carryinsel,
    output logic        dsp_carryin,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    localparam logic [6:0] OPM_FIRST   = 7'h05; // X=M, Y=M, Z=0
    localparam logic [6:0] OPM_NEXT    = 7'h25; // X=M, Y=M, Z=P
    localparam logic [6:0] OPM_HOLD    = 7'h20; // Z=P only: P keeps its value
    localparam logic [6:0] OPM_IDLE    = 7'h00;

    state_t      state_q;
    logic [29:0] a_q;
    logic [17:0] b_q;
    logic [6:0]  tag_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [7:0]  drain_q;
    logic [47:0] data_q;
    logic        valid_q;
    logic        trunc_q;
    logic        trunc_pend_q;
    logic        accept;
    logic        hit_limit;
    logic        close;

    assign s_ready = ~rst & ((state_q == IDLE) | (state_q == ACCUM));
    assign accept  = s_valid & s_ready;

    // Next term count: restarts at 1 on the first term, saturates at 16'hFFFF.
    always_comb begin
        cnt_d = 16'd1;
        if (state_q != IDLE) begin
            cnt_d = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
        end
    end

`ifdef DSPMAC_TERM_LIMIT_EN
    assign hit_limit = (cnt_d == 16'(MAX_TERMS));
`else
    assign hit_limit = 1'b0;
`endif
    assign close = s_last | hit_limit;

    // Main sequencer: operand/tag registers, term counting, drain timing, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= OPM_IDLE;
            cnt_q        <= '0;
            drain_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            trunc_q      <= 1'b0;
            trunc_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        a_q          <= {{5{s_a[24]}}, s_a};
                        b_q          <= s_b;
                        tag_q        <= (state_q == IDLE) ? OPM_FIRST : OPM_NEXT;
                        cnt_q        <= cnt_d;
                        trunc_pend_q <= hit_limit & ~s_last;
                        drain_q      <= '0;
                        state_q      <= close ? DRAIN : ACCUM;
                    end else begin
                        tag_q <= (state_q == IDLE) ? OPM_IDLE : OPM_HOLD;
                    end
                end
                DRAIN: begin
                    tag_q <= OPM_HOLD;
                    if (drain_q == 8'(P_LAT)) begin
                        data_q  <= dsp_p;
                        valid_q <= 1'b1;
                        trunc_q <= trunc_pend_q;
                        state_q <= HOLD;
                    end else begin
                        drain_q <= drain_q + 8'd1;
                    end
                end
                HOLD: begin
                    tag_q <= OPM_HOLD;
                    if (m_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Opmode delay line aligns each tag with its product reaching the ALU.
    generate
        if (OPM_DLY == 0) begin : g_opm_direct
            assign dsp_opmode = tag_q;
        end else begin : g_opm_delay
            logic [6:0] dly_q [OPM_DLY];
            // Shift tags one stage per cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < OPM_DLY; i++) dly_q[i] <= OPM_IDLE;
                end else begin
                    dly_q[0] <= tag_q;
                    for (int i = 1; i < OPM_DLY; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign dsp_opmode = dly_q[OPM_DLY-1];
        end
    endgenerate

    assign dsp_a          = a_q;
    assign dsp_b          = b_q;
    assign dsp_alumode    = 4'b0000;
    assign dsp_inmode     = 5'b00000;
    assign dsp_carryinsel = 3'b000;
    assign dsp_carryin    = 1'b0;
    assign dsp_ce         = ~rst;
    assign dsp_rst        = rst;

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_count = cnt_q;
    assign m_trunc = trunc_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: DSP48E1 slice model (AREG=BREG=MREG=PREG=1,
// OPMODEREG=1), dot-product reference model feeding an expected queue, and a
// monitor that checks every result handshake plus hold/latency behaviour.
module tb_dsp_mac_sequencer;
  localparam int TB_P_LAT = 3;
  localparam int TB_OPM_DLY = 1;
  localparam int TB_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [24:0] s_a = '0;
  logic [17:0] s_b = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [47:0] m_data;
  logic [15:0] m_count;
  logic        m_trunc;
  logic [29:0] dsp_a;
  logic [17:0] dsp_b;
  logic [6:0]  dsp_opmode;
  logic [3:0]  dsp_alumode;
  logic [4:0]  dsp_inmode;
  logic [2:0]  dsp_carryinsel;
  logic        dsp_carryin;
  logic        dsp_ce;
  logic        dsp_rst;
  logic [47:0] dsp_p;

  dsp_mac_sequencer #(.P_LAT(TB_P_LAT), .OPM_DLY(TB_OPM_DLY), .MAX_TERMS(TB_MAX)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
    .m_trunc(m_trunc),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode),
    .dsp_inmode(dsp_inmode), .dsp_carryinsel(dsp_carryinsel), .dsp_carryin(dsp_carryin),
    .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  // ---------------- DSP48E1 slice model ----------------
  logic signed [29:0] sl_a;
  logic signed [17:0] sl_b;
  logic signed [47:0] sl_m;
  logic signed [47:0] sl_p;
  logic [6:0]         sl_opm;
  logic signed [47:0] sl_xy;
  logic signed [47:0] sl_z;
  assign sl_xy = (sl_opm[3:0] == 4'b0101) ? sl_m : 48'sd0;
  assign sl_z  = (sl_opm[6:4] == 3'b010) ? sl_p : 48'sd0;
  always @(posedge clk) begin
    if (dsp_rst) begin
      sl_a <= '0; sl_b <= '0; sl_m <= '0; sl_p <= '0; sl_opm <= '0;
    end else if (dsp_ce) begin
      sl_a   <= dsp_a;
      sl_b   <= dsp_b;
      sl_m   <= sl_a * sl_b;
      sl_opm <= dsp_opmode;
      sl_p   <= sl_z + sl_xy + {47'd0, dsp_carryin};
    end
  end
  assign dsp_p = sl_p;

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];   // {trunc, count[15:0], data[47:0]}
  int vectors = 0;
  int miscompares = 0;
  longint mdl_sum = 0;
  int mdl_cnt = 0;
  int last_cyc = 0;
  bit force_low = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [64:0] act,
                     input logic [64:0] req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference dot-product model: one accepted term.
  task automatic model_accept(input int a, input int b, input bit last);
    bit close;
    bit trunc;
    mdl_sum += longint'(a) * longint'(b);
    mdl_cnt++;
    close = last;
    trunc = 1'b0;
`ifdef DSPMAC_TERM_LIMIT_EN
    if (mdl_cnt == TB_MAX) begin
      close = 1'b1;
      trunc = !last;
    end
`endif
    if (close) begin
      exp_q.push_back({trunc, 16'(mdl_cnt), mdl_sum[47:0]});
      mdl_sum = 0;
      mdl_cnt = 0;
      last_cyc = cyc + 1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_term(input int a, input int b, input bit last, input int gap);
    int budget;
    budget = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_a = 25'(a);
    s_b = 18'(b);
    s_last = last;
    while (!s_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) begin
      chk(1'b0, "s_ready_timeout", 65'(s_ready), 65'd1);
      s_valid = 1'b0;
    end else begin
      model_accept(a, b, last);
      @(posedge clk);
      #1 s_valid = 1'b0;
      s_last = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || m_valid) && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    chk(exp_q.size() == 0, "drain_timeout", 65'(exp_q.size()), 65'd0);
  endtask

  task automatic check_reset_state();
    chk(s_ready == 1'b0, "rst_s_ready", 65'(s_ready), 65'd0);
    chk(m_valid == 1'b0, "rst_m_valid", 65'(m_valid), 65'd0);
    chk({m_trunc, m_count, m_data} == 65'd0, "rst_result", {m_trunc, m_count, m_data}, 65'd0);
    chk({dsp_a, dsp_b, dsp_opmode} == 55'd0, "rst_operands", 65'({dsp_a, dsp_b, dsp_opmode}), 65'd0);
    chk({dsp_ce, dsp_rst} == 2'b01, "rst_ce_rst", 65'({dsp_ce, dsp_rst}), 65'd1);
    chk({dsp_alumode, dsp_inmode, dsp_carryinsel, dsp_carryin} == 13'd0, "const_ctrl",
        65'({dsp_alumode, dsp_inmode, dsp_carryinsel, dsp_carryin}), 65'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (cycles) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    mdl_sum = 0;
    mdl_cnt = 0;
  endtask

  // Result consumer: random backpressure, or held low on request.
  always @(posedge clk) begin
    #1 m_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  bit          prev_valid = 1'b0;
  bit          hs_prev = 1'b0;
  logic [64:0] held = '0;
  logic [64:0] exp_item;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk(s_ready == 1'b1 && m_valid == 1'b0, "after_handshake",
            65'({s_ready, m_valid}), 65'b10);
      end
      if (m_valid) begin
        chk(s_ready == 1'b0, "hold_s_ready", 65'(s_ready), 65'd0);
        if (!prev_valid) begin
          chk(cyc - last_cyc == TB_P_LAT + 1, "latency", 65'(cyc - last_cyc), 65'(TB_P_LAT + 1));
        end else begin
          chk({m_trunc, m_count, m_data} == held, "hold_stable", {m_trunc, m_count, m_data}, held);
        end
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_result", {m_trunc, m_count, m_data}, 65'd0);
          end else begin
            exp_item = exp_q.pop_front();
            chk({m_trunc, m_count, m_data} == exp_item, "result", {m_trunc, m_count, m_data}, exp_item);
          end
        end
      end
      prev_valid = m_valid;
      held = {m_trunc, m_count, m_data};
      hs_prev = m_valid && m_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    int len;
    int ra;
    int rb;
    int gap;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    chk(s_ready == 1'b1, "ready_after_rst", 65'(s_ready), 65'd1);

    // Back-to-back three terms: -5.
    send_term(3, 4, 1'b0, 0);
    send_term(-2, 5, 1'b0, 0);
    send_term(7, -1, 1'b1, 0);
    wait_drain();

    // Single full-scale negative term.
    send_term(-(2 ** 24), -(2 ** 17), 1'b1, 0);
    wait_drain();

    // Gapped unit terms: bubbles contribute nothing.
    for (int i = 0; i < 5; i++) send_term(1, 1, i == 4, 2);
    wait_drain();

    // Backpressure in HOLD for 6 cycles.
    force_low = 1'b1;
    send_term(5, 6, 1'b1, 0);
    budget = 0;
    while (!m_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk(m_valid == 1'b1, "hold_reach", 65'(m_valid), 65'd1);
    repeat (6) @(negedge clk);
    force_low = 1'b0;
    wait_drain();

    // Reset mid dot product aborts it.
    send_term(9, 9, 1'b0, 0);
    send_term(8, 8, 1'b0, 0);
    do_reset(2);
    send_term(2, 3, 1'b0, 0);
    send_term(2, 3, 1'b1, 0);
    wait_drain();

    // Six unit terms, sixth last (splits under the term limit).
    for (int i = 0; i < 6; i++) send_term(1, 1, i == 5, 0);
    wait_drain();

    // 32 full-scale terms stay exact.
    for (int i = 0; i < 32; i++) send_term(-(2 ** 24), -(2 ** 17), i == 31, 0);
    wait_drain();

    // Random dot products.
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        ra = int'($urandom_range(0, 2 ** 25 - 1)) - 2 ** 24;
        rb = int'($urandom_range(0, 2 ** 18 - 1)) - 2 ** 17;
        gap = $urandom_range(0, 2);
        send_term(ra, rb, i == len - 1, gap);
      end
    end
    wait_drain();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end
endmodule
